// File: rtl/multi_time_counter.sv
`default_nettype none
// ============================================================================
//  Module   : multi_time_counter
//  Purpose  : Tick-driven up-counter with a programmable limit and N
//             programmable threshold channels. At the limit the counter
//             either saturates (mode=0) or wraps to zero (mode=1). Each
//             channel reports a level (cnt >= threshold) and a one-cycle
//             pulse when the count is freshly loaded with a value equal to
//             its threshold.
//
//  Ports    :
//    clk1      in   1            clock, all state updates on rising edge
//    st        in   1            asynchronous active-high reset
//    restart   in   1            synchronous restart of the count to 0
//    tick      in   1            count enable, one increment per edge
//    mode      in   1            0 = saturate at limit, 1 = wrap at limit
//    cfg_we    in   1            configuration write strobe
//    cfg_idx   in   clog2(N+1)   0..N-1 threshold channel, N = limit reg
//    cfg_data  in   W            configuration write data
//    cnt       out  W            current count
//    hit       out  N            per channel level: cnt >= th[i]
//    hit_p     out  N            per channel pulse: cnt newly equals th[i]
//    wrap_p    out  1            pulse in the cycle after a wrap
//    done      out  1            mode=0 and cnt == lim
//
//  Revision : 1.0  initial release
// ============================================================================
module multi_time_counter #(
   parameter int               W        = 8,
   parameter int               N        = 3,
   parameter logic [N*W-1:0]   TH_INIT  = {W'(29), W'(14), W'(4)},
   parameter logic [W-1:0]     LIM_INIT = W'(29)
) (
   input  logic                      clk1,
   input  logic                      st,
   input  logic                      restart,
   input  logic                      tick,
   input  logic                      mode,
   input  logic                      cfg_we,
   input  logic [$clog2(N+1)-1:0]    cfg_idx,
   input  logic [W-1:0]              cfg_data,
   output logic [W-1:0]              cnt,
   output logic [N-1:0]              hit,
   output logic [N-1:0]              hit_p,
   output logic                      wrap_p,
   output logic                      done
);

   localparam int             c_iw      = $clog2(N+1);
   localparam logic [c_iw-1:0] c_lim_idx = c_iw'(N);

   logic [W-1:0] r_cnt;
   logic [W-1:0] r_lim;
   logic [W-1:0] r_th [N];
   logic         r_upd;      // count was loaded at the last edge
   logic         r_wrap_p;

   logic         w_below_lim;
   logic         w_lim_we;

   // Compared against the limit value in force before this edge, so a
   // simultaneous limit write only affects the following updates.
   assign w_below_lim = (r_cnt < r_lim);
   assign w_lim_we    = cfg_we && (cfg_idx == c_lim_idx);

   // ------------------------------------------------------------------------
   // Count register. Restart wins over tick. At or above the limit the count
   // holds in saturate mode (no load, hence no pulses) or reloads to zero in
   // wrap mode. Because increments only happen below the limit, the count
   // can never overflow W bits.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk1 or posedge st) begin
      if (st) begin
         r_cnt    <= '0;
         r_upd    <= 1'b0;
         r_wrap_p <= 1'b0;
      end else begin
         r_upd    <= 1'b0;
         r_wrap_p <= 1'b0;
         if (restart) begin
            r_cnt <= '0;
            r_upd <= 1'b1;
         end else if (tick) begin
            if (w_below_lim) begin
               r_cnt <= r_cnt + W'(1);
               r_upd <= 1'b1;
            end else if (mode) begin
               r_cnt    <= '0;
               r_upd    <= 1'b1;
               r_wrap_p <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Limit register. Lowering it below the current count is legal: the count
   // then simply stays put (saturate) or wraps on the next tick (wrap mode).
   // ------------------------------------------------------------------------
   always_ff @(posedge clk1 or posedge st) begin
      if (st) begin
         r_lim <= LIM_INIT;
      end else if (w_lim_we) begin
         r_lim <= cfg_data;
      end
   end

   // ------------------------------------------------------------------------
   // Threshold channels. Each channel owns its register and its comparators;
   // out-of-range indices match no channel and no limit, so they are dropped.
   // ------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ch
         always_ff @(posedge clk1 or posedge st) begin
            if (st) begin
               r_th[gi] <= TH_INIT[gi*W +: W];
            end else if (cfg_we && (cfg_idx == c_iw'(gi))) begin
               r_th[gi] <= cfg_data;
            end
         end

         // A zero threshold is always reached; its pulse still needs a load,
         // so it fires once after a restart or wrap.
         assign hit[gi]   = (r_cnt >= r_th[gi]);
         assign hit_p[gi] = r_upd && (r_cnt == r_th[gi]);
      end
   endgenerate

   assign cnt    = r_cnt;
   assign wrap_p = r_wrap_p;
   assign done   = !mode && (r_cnt == r_lim);

endmodule
`default_nettype wire

// File: tb/tb_multi_time_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_time_counter
//  Purpose  : Scoreboard bench for multi_time_counter. The stimulus process
//             applies one directed vector per clock, advances a small
//             reference model and queues the expected outputs; a monitor
//             process pops and compares on every falling edge (and once right
//             after an asynchronous reset assertion).
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_time_counter;

   logic       clk1 = 1'b0;
   logic       st;
   logic       restart;
   logic       tick;
   logic       mode;
   logic       cfg_we;
   logic [1:0] cfg_idx;
   logic [7:0] cfg_data;
   logic [7:0] cnt;
   logic [2:0] hit;
   logic [2:0] hit_p;
   logic       wrap_p;
   logic       done;

   multi_time_counter dut (
      .clk1     (clk1),
      .st       (st),
      .restart  (restart),
      .tick     (tick),
      .mode     (mode),
      .cfg_we   (cfg_we),
      .cfg_idx  (cfg_idx),
      .cfg_data (cfg_data),
      .cnt      (cnt),
      .hit      (hit),
      .hit_p    (hit_p),
      .wrap_p   (wrap_p),
      .done     (done)
   );

   always #5 clk1 = ~clk1;

   typedef struct packed {
      logic [7:0] cnt;
      logic [2:0] hit;
      logic [2:0] hitp;
      logic       wrap;
      logic       done;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   logic chk_now  = 1'b0;

   // reference model state
   int   m_cnt;
   int   m_lim;
   int   m_th[3];
   logic m_upd;
   logic m_wrap;

   task automatic model_reset();
      m_cnt  = 0;
      m_lim  = 29;
      m_th[0] = 4;
      m_th[1] = 14;
      m_th[2] = 29;
      m_upd  = 1'b0;
      m_wrap = 1'b0;
   endtask

   task automatic model_edge();
      int   ncnt;
      logic nupd;
      logic nwrap;
      if (st) begin
         model_reset();
      end else begin
         ncnt  = m_cnt;
         nupd  = 1'b0;
         nwrap = 1'b0;
         if (restart) begin
            ncnt = 0;
            nupd = 1'b1;
         end else if (tick) begin
            if (m_cnt < m_lim) begin
               ncnt = m_cnt + 1;
               nupd = 1'b1;
            end else if (mode) begin
               ncnt  = 0;
               nupd  = 1'b1;
               nwrap = 1'b1;
            end
         end
         if (cfg_we) begin
            if (cfg_idx == 2'd3) m_lim = int'(cfg_data);
            else                 m_th[cfg_idx] = int'(cfg_data);
         end
         m_cnt  = ncnt;
         m_upd  = nupd;
         m_wrap = nwrap;
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.cnt  = 8'(m_cnt);
      for (int i = 0; i < 3; i++) begin
         e.hit[i]  = (m_cnt >= m_th[i]);
         e.hitp[i] = m_upd && (m_cnt == m_th[i]);
      end
      e.wrap = m_wrap;
      e.done = !mode && (m_cnt == m_lim);
      q.push_back(e);
   endtask

   // One clock of stimulus; returns shortly after the falling edge so the
   // inputs never move while the monitor samples.
   task automatic step(input logic rs, input logic tk, input logic md,
                       input logic we, input logic [1:0] idx,
                       input logic [7:0] data);
      restart  = rs;
      tick     = tk;
      mode     = md;
      cfg_we   = we;
      cfg_idx  = idx;
      cfg_data = data;
      @(posedge clk1);
      model_edge();
      push_exp();
      @(negedge clk1);
      #1;
   endtask

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk1 or posedge chk_now);
         if (q.size() > 0) begin
            e = q.pop_front();
            cmp("cnt",    int'(cnt),    int'(e.cnt));
            cmp("hit",    int'(hit),    int'(e.hit));
            cmp("hit_p",  int'(hit_p),  int'(e.hitp));
            cmp("wrap_p", int'(wrap_p), int'(e.wrap));
            cmp("done",   int'(done),   int'(e.done));
         end
      end
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      st = 1'b1;
      restart = 1'b0; tick = 1'b0; mode = 1'b0;
      cfg_we = 1'b0; cfg_idx = 2'd0; cfg_data = 8'd0;
      model_reset();

      // reset state, then idle after release
      repeat (2) step(0, 0, 0, 0, 2'd0, 8'd0);
      st = 1'b0;
      repeat (2) step(0, 0, 0, 0, 2'd0, 8'd0);

      // saturate run with defaults
      step(1, 1, 0, 0, 2'd0, 8'd0);
      repeat (40) step(0, 1, 0, 0, 2'd0, 8'd0);

      // auto-reload run
      repeat (40) step(0, 1, 1, 0, 2'd0, 8'd0);

      // restart + tick on the same edge at cnt=10, then idle
      step(1, 0, 1, 0, 2'd0, 8'd0);
      repeat (10) step(0, 1, 1, 0, 2'd0, 8'd0);
      step(1, 1, 1, 0, 2'd0, 8'd0);
      repeat (5) step(0, 0, 1, 0, 2'd0, 8'd0);

      // zero threshold on channel 0, then restart
      step(0, 0, 0, 1, 2'd0, 8'd0);
      step(1, 0, 0, 0, 2'd0, 8'd0);
      repeat (5) step(0, 1, 0, 0, 2'd0, 8'd0);
      // limit 7, saturate there
      step(0, 0, 0, 1, 2'd3, 8'd7);
      repeat (5) step(0, 1, 0, 0, 2'd0, 8'd0);
      // limit write together with tick: old limit governs this edge
      step(0, 1, 0, 1, 2'd3, 8'd29);
      repeat (3) step(0, 1, 0, 0, 2'd0, 8'd0);
      // limit lowered below count: hold in mode 0, wrap in mode 1
      step(0, 0, 0, 1, 2'd3, 8'd5);
      repeat (3) step(0, 1, 0, 0, 2'd0, 8'd0);
      repeat (4) step(0, 1, 1, 0, 2'd0, 8'd0);

      // threshold above limit never hits in wrap mode
      step(0, 0, 1, 1, 2'd2, 8'd40);
      step(0, 0, 1, 1, 2'd3, 8'd29);
      repeat (35) step(0, 1, 1, 0, 2'd0, 8'd0);
      // saturate, then raise the limit past the threshold
      step(1, 0, 0, 0, 2'd0, 8'd0);
      repeat (32) step(0, 1, 0, 0, 2'd0, 8'd0);
      step(0, 0, 0, 1, 2'd3, 8'd45);
      repeat (14) step(0, 1, 0, 0, 2'd0, 8'd0);

      // asynchronous reset mid-count after a config change
      step(0, 0, 0, 1, 2'd0, 8'd9);
      step(1, 0, 0, 0, 2'd0, 8'd0);
      repeat (20) step(0, 1, 0, 0, 2'd0, 8'd0);
      st = 1'b1;
      #2;
      model_reset();
      push_exp();
      chk_now = 1'b1;
      #1;
      chk_now = 1'b0;
      step(0, 1, 0, 1, 2'd3, 8'd3);
      st = 1'b0;
      repeat (3) step(0, 0, 0, 0, 2'd0, 8'd0);
      repeat (16) step(0, 1, 0, 0, 2'd0, 8'd0);

      step(0, 0, 0, 0, 2'd0, 8'd0);
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multi_time_counter.md
MULTI_TIME_COUNTER -- requirements
Module: multi_time_counter

Interface
REQ-001 Parameter W, default 8: counter and threshold width in bits.
REQ-002 Parameter N, default 3: number of threshold channels (1..8).
REQ-003 Parameter TH_INIT, default {29,14,4} (packed N*W, channel 0 in LSBs): threshold values loaded at reset.
REQ-004 Parameter LIM_INIT, default 29: count limit loaded at reset.
REQ-005 clk1  in  1  single clock; all state updates on its rising edge.
REQ-006 st  in  1  reset, asynchronous and active-high.
REQ-007 restart  in  1  synchronous restart of the count.
REQ-008 tick  in  1  count-enable strobe; one increment per clk1 edge with tick=1.
REQ-009 mode  in  1  0 = saturate at limit, 1 = auto-reload (wrap) at limit.
REQ-010 cfg_we  in  1  configuration write strobe.
REQ-011 cfg_idx  in  $clog2(N+1)  target: 0..N-1 threshold channel, N = limit register.
REQ-012 cfg_data  in  W  value written.
REQ-013 cnt  out  W  current count.
REQ-014 hit  out  N  level per channel: cnt >= th[i].
REQ-015 hit_p  out  N  one-cycle pulse per channel when cnt newly equals th[i].
REQ-016 wrap_p  out  1  one-cycle pulse on the cycle after a wrap.
REQ-017 done  out  1  level: mode=0 and cnt == lim.

Function
REQ-018 Count update priority per clk1 edge: restart, then tick; restart+tick same edge -> cnt=0, tick ignored.
REQ-019 tick=1, cnt<lim -> cnt+1.
REQ-020 tick=1, cnt>=lim, mode=0 -> cnt holds (saturate); no hit_p, no wrap_p.
REQ-021 tick=1, cnt>=lim, mode=1 -> cnt=0 next edge; wrap_p=1 in the following cycle only.
REQ-022 tick=0, restart=0 -> cnt holds.
REQ-023 Counting arithmetic unsigned, W bits; cnt never exceeds max(lim, value at limit lowering); no binary overflow wrap (lim <= 2^W-1).
REQ-024 hit[i] combinational from registered cnt and th[i]; th[i]=0 -> hit[i]=1 at all times.
REQ-025 Internal flag upd=1 for exactly the cycle after any cnt load (restart, increment, wrap); hit_p[i] = upd & (cnt == th[i]).
REQ-026 Restart with th[i]=0 -> hit_p[i] pulses once in the cycle after restart.
REQ-027 th[i] > lim -> hit[i], hit_p[i] never assert in mode 1; in mode 0 only if lim later raised.
REQ-028 cfg_we=1 -> target register takes cfg_data at the edge; new value governs hit/done from the next cycle; cfg_idx > N ignored.
REQ-029 Config write simultaneous with count update: both take effect at the same edge; count update uses the old lim.
REQ-030 lim written below current cnt: mode=0 -> cnt holds, done=0 until restart (cnt != lim); mode=1 -> next tick wraps to 0.
REQ-031 mode change mid-count takes effect on the next tick; cnt not modified by the change itself.
REQ-032 wrap_p and hit_p are never asserted for more than one consecutive cycle per event.

Reset
REQ-033 st=1 asynchronously forces cnt=0, th=TH_INIT, lim=LIM_INIT, upd=0, wrap_p=0; hence hit_p=0 during and directly after reset.
REQ-034 Reset mid-count discards count and all configuration writes; counting resumes from 0 on first tick after st deasserts.
REQ-035 Outputs after reset with defaults: cnt=0, hit=000, hit_p=000, wrap_p=0, done=0.

Verification
REQ-036 Defaults, mode=0, restart then tick held 1 -> hit[0] rises at cnt=4 (hit_p[0] pulse same cycle), hit[1] at 14, hit[2] and done at 29; cnt stays 29 after 40 ticks.
REQ-037 mode=1, tick held -> cnt 29 -> 0, wrap_p one cycle with cnt=0, hit drops to 000, hit_p[0] pulses again at next cnt=4.
REQ-038 cnt=10, restart=1 and tick=1 same edge -> cnt=0, hit=000; tick=0 for 5 cycles -> cnt stays 0, no pulses.
REQ-039 cfg write idx=0 data=0 then restart -> hit[0]=1 throughout, hit_p[0] single pulse after restart; write idx=3 data=7, mode=0 -> saturate at 7, done=1, hit[1]=0.
REQ-040 st asserted at cnt=20 between edges -> cnt=0 immediately, prior cfg writes reverted to 4/14/29/29, no hit_p after release.
